wmem_banked_stream: RTL
=======================

Name: wmem_banked_stream

Overview:
- Parametrised successor of the 16-bank weight buffer for the GEMM core.
- Host side: byte-addressed single-word read/write to any bank, unchanged in behaviour.
- Engine side: a burst streamer replaces per-row reads. The engine gives a base row and a length. The block then streams full-width rows (all banks concatenated) through a valid/ready interface, using an output FIFO that absorbs backpressure.
- Banks are inferred synchronous single-port RAMs inside the block, with 1-cycle read latency.

Parameters:
- BUFF_ADDR_WIDTH, 14: host address width; must equal 2 + ROW_ADDR_WIDTH + log2(NUM_BANKS) + log2(BUFF_DATA_WIDTH/8).
- BUFF_DATA_WIDTH, 32: host word width, which is also the bank width.
- NUM_BANKS, 16: number of banks (power of two, at least 2).
- ROW_ADDR_WIDTH, 6: row address width; bank depth is 2^ROW_ADDR_WIDTH.
- MEM_SEL, 1: value of host address bits [BUFF_ADDR_WIDTH-1 -: 2] that selects this buffer.
- FIFO_DEPTH, 4: depth of the engine output FIFO in rows (power of two, at least 2).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- mem_cen, in, 1: host access enable.
- mem_wen, in, 1: host write (1) or read (0).
- mem_addr, in, BUFF_ADDR_WIDTH: host address, laid out as {sel[1:0], row, bank, byte}.
- mem_din, in, BUFF_DATA_WIDTH: host write data.
- mem_dout, out, BUFF_DATA_WIDTH: host read data.
- mem_valid, out, 1: host read data valid.
- w_start, in, 1: one-cycle pulse that starts a burst.
- w_base, in, ROW_ADDR_WIDTH: first row of the burst.
- w_len, in, ROW_ADDR_WIDTH+1: number of rows, 0 to 2^ROW_ADDR_WIDTH.
- w_busy, out, 1: a burst is active.
- w_done, out, 1: one-cycle pulse when the last beat is accepted.
- w_rd_data, out, NUM_BANKS*BUFF_DATA_WIDTH: row data; bank 0 occupies the MSBs.
- w_rd_valid, out, 1: row beat valid.
- w_rd_ready, in, 1: consumer accepts the beat.
- w_rd_last, out, 1: marks the final beat of the burst.
- conflict_cnt, out, 16: count of engine reads deferred by host accesses; saturates at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, the FSM goes to IDLE and the FIFO is emptied.
  - RAM contents are not cleared.
  - A reset during a burst aborts it with no w_done.
- Host hit condition: mem_cen=1 and sel==MEM_SEL. Only the bank indexed by the bank field is enabled, at row = row field.
  - Write: the word is stored at the clock edge.
  - Read: mem_valid=1 and mem_dout=word one cycle later; both are 0 otherwise.
  - A non-hit access is ignored, and mem_valid stays 0.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE, w_start with w_len>0: latch base and len, set issue_ptr=base and remaining issues = len, go to RUN. w_busy=1 from the next cycle.
  - IDLE, w_start with w_len=0: no beats; w_done pulses the next cycle and w_busy stays 0.
  - RUN: issue a full-row read (all banks, row issue_ptr) in a cycle when all of these hold:
    - no host hit;
    - issues remain;
    - fifo_count + inflight < FIFO_DEPTH, where inflight=1 if a read was issued in the previous cycle.
  - RUN, host hit in a cycle where an issue was otherwise allowed: the host wins, the engine retries next cycle, and conflict_cnt increments.
  - issue_ptr increments modulo 2^ROW_ADDR_WIDTH, so it wraps from the top row to row 0.
  - RUN to DRAIN once the last read has been issued.
  - DRAIN to IDLE on the handshake (valid and ready) of the last beat; w_done pulses that same cycle and w_busy drops the next cycle.
  - w_start is ignored while w_busy=1.
- Read data: RAM output is written into the FIFO in the cycle after issue.
  - w_rd_valid = FIFO not empty, and w_rd_data = FIFO head. w_rd_data is 0 when w_rd_valid=0.
  - Data must be held stable while valid=1 and ready=0.
  - w_rd_last=1 on the head entry that is the burst's final row.
- Latency: with w_start at cycle T and no conflicts, the first read issues at T+1 and w_rd_valid rises at T+3.
  - With ready held at 1, the block sustains one beat per cycle.
- Simultaneous events:
  - A FIFO push and pop in the same cycle leave the count unchanged.
  - A host write and an engine read never occur in the same cycle, because of host priority.
  - A host write to a row already read by the engine does not affect FIFO contents.
- conflict_cnt is cleared only by reset.

Test Plan:
1. Host writes 0xA0000000+16*r+b to every bank b and row r, then reads back row 5, bank 3. Required: mem_dout=0xA0000053 with mem_valid one cycle after the request. A read with sel=2 gives mem_valid=0.
2. Burst with w_base=2, w_len=4 and ready=1. Required: beats for rows 2–5 on cycles T+3 to T+6, bank 0 in the MSBs, w_rd_last on row 5, w_done at T+6.
3. Same burst with ready toggling 1,0,0,1. Required: no beat lost or duplicated, data stable while stalled, and FIFO occupancy never above FIFO_DEPTH.
4. Host reads in 3 consecutive cycles during a burst. Required: conflict_cnt=3, all rows delivered in order, and w_done 3 cycles later than in scenario 2.
5. w_base=62, w_len=4. Required: rows 62, 63, 0, 1. Then w_len=0: w_done one cycle after w_start, no beats.
6. Reset asserted after 2 beats of an 8-row burst. Required: outputs 0 immediately, no w_done. A new burst afterwards is correct and RAM contents are intact.

Source files
------------

// File: rtl/wmem_banked_stream.sv
// Banked weight buffer: host word access to any bank plus an engine-side burst
// streamer that delivers full-width rows through a backpressure-absorbing FIFO.
module wmem_banked_stream #(
   parameter int BUFF_ADDR_WIDTH = 14,
   parameter int BUFF_DATA_WIDTH = 32,
   parameter int NUM_BANKS       = 16,
   parameter int ROW_ADDR_WIDTH  = 6,
   parameter int MEM_SEL         = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 mem_cen,
   input  logic                                 mem_wen,
   input  logic [BUFF_ADDR_WIDTH-1:0]           mem_addr,
   input  logic [BUFF_DATA_WIDTH-1:0]           mem_din,
   output logic [BUFF_DATA_WIDTH-1:0]           mem_dout,
   output logic                                 mem_valid,
   input  logic                                 w_start,
   input  logic [ROW_ADDR_WIDTH-1:0]            w_base,
   input  logic [ROW_ADDR_WIDTH:0]              w_len,
   output logic                                 w_busy,
   output logic                                 w_done,
   output logic [NUM_BANKS*BUFF_DATA_WIDTH-1:0] w_rd_data,
   output logic                                 w_rd_valid,
   input  logic                                 w_rd_ready,
   output logic                                 w_rd_last,
   output logic [15:0]                          conflict_cnt
);
   localparam int BYTE_W = $clog2(BUFF_DATA_WIDTH / 8);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int DEPTH  = 1 << ROW_ADDR_WIDTH;
   localparam int RW     = NUM_BANKS * BUFF_DATA_WIDTH;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W:0] FIFO_FULL = (CNT_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]                 host_sel;
   logic [ROW_ADDR_WIDTH-1:0]  host_row;
   logic [BANK_W-1:0]          host_bank;
   logic                       host_hit;
   logic                       unused_byte;

   logic [1:0]                 state;
   logic [ROW_ADDR_WIDTH-1:0]  issue_ptr;
   logic [ROW_ADDR_WIDTH:0]    remaining;
   logic                       inflight;
   logic                       inflight_last;
   logic                       zero_done;
   logic                       can_issue;
   logic                       issue;
   logic                       conflict;
   logic [CNT_W:0]             occupancy;

   logic [ROW_ADDR_WIDTH-1:0]  ram_addr;
   logic [RW-1:0]              row_q;
   logic                       host_rd_q;
   logic [BANK_W-1:0]          host_bank_q;
   logic [BUFF_DATA_WIDTH-1:0] host_word;

   logic [RW:0]                fifo_mem [FIFO_DEPTH];
   logic [RW:0]                head;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           fifo_count;
   logic                       push;
   logic                       pop;
   logic                       last_pop;

   assign host_sel    = mem_addr[BUFF_ADDR_WIDTH-1 -: 2];
   assign host_row    = mem_addr[BYTE_W+BANK_W +: ROW_ADDR_WIDTH];
   assign host_bank   = mem_addr[BYTE_W +: BANK_W];
   assign host_hit    = mem_cen && (host_sel == 2'(MEM_SEL));
   assign unused_byte = ^mem_addr[BYTE_W-1:0];

   // Room check counts the read already in the RAM pipeline so the FIFO never overflows.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
   assign can_issue = (state == ST_RUN) && (remaining != '0) && (occupancy < FIFO_FULL);
   assign issue     = can_issue && !host_hit;
   assign conflict  = can_issue && host_hit;
   assign ram_addr  = host_hit ? host_row : issue_ptr;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [BUFF_DATA_WIDTH-1:0] ram [DEPTH];
      logic [BUFF_DATA_WIDTH-1:0] q;
      logic                       sel_b;

      assign sel_b = host_hit && (host_bank == BANK_W'(b));

      always_ff @(posedge clk) begin
         if (sel_b && mem_wen) ram[ram_addr] <= mem_din;
         if ((sel_b && !mem_wen) || issue) q <= ram[ram_addr];
      end

      assign row_q[(NUM_BANKS-1-b)*BUFF_DATA_WIDTH +: BUFF_DATA_WIDTH] = q;
   end

   always_comb begin
      host_word = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (host_bank_q == BANK_W'(b))
            host_word = row_q[(NUM_BANKS-1-b)*BUFF_DATA_WIDTH +: BUFF_DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         host_rd_q   <= 1'b0;
         host_bank_q <= '0;
      end else begin
         host_rd_q   <= host_hit && !mem_wen;
         host_bank_q <= host_bank;
      end
   end

   assign mem_valid = host_rd_q;
   assign mem_dout  = host_rd_q ? host_word : '0;

   assign push       = inflight;
   assign w_rd_valid = (fifo_count != '0);
   assign pop        = w_rd_valid && w_rd_ready;
   assign head       = fifo_mem[rd_ptr];
   assign last_pop   = pop && head[RW];
   assign w_rd_data  = w_rd_valid ? head[RW-1:0] : '0;
   assign w_rd_last  = w_rd_valid && head[RW];
   assign w_busy     = (state != ST_IDLE);
   assign w_done     = zero_done || ((state == ST_DRAIN) && last_pop);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {inflight_last, row_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         issue_ptr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         zero_done     <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         conflict_cnt  <= '0;
      end else begin
         zero_done     <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remaining == (ROW_ADDR_WIDTH + 1)'(1));

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
         else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);

         if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 16'd1;

         case (state)
            ST_IDLE: begin
               if (w_start) begin
                  if (w_len == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     issue_ptr <= w_base;
                     remaining <= w_len;
                     state     <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (issue) begin
                  issue_ptr <= issue_ptr + ROW_ADDR_WIDTH'(1);
                  remaining <= remaining - (ROW_ADDR_WIDTH + 1)'(1);
                  if (remaining == (ROW_ADDR_WIDTH + 1)'(1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_pop) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
